// File: rtl/tx_escape.sv
// Transmit-side escaper between the TAP and UART-TX: command bytes and data bytes
// equal to ESC are preceded by an ESC symbol, everything else passes through.
module tx_escape #(
  parameter logic [7:0] ESC = 8'hB1
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic [7:0] DATA_SEND_I,
  input  logic       COMMAND_I,
  input  logic       WRITE_I,
  output logic       TX_READY_O,
  input  logic       TX_READY_I,
  output logic       WRITE_O,
  output logic [7:0] DATA_SEND_O
);

  typedef enum logic [2:0] {
    st_idle,
    st_escape,
    st_esc_gap,
    st_data,
    st_gap
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       tx_ready;
  logic       write;
  logic [7:0] data_out;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    tx_ready = 1'b0;
    write    = 1'b0;
    data_out = 8'h00;
    case (state_q)
      st_idle: begin
        tx_ready = 1'b1;
        if (WRITE_I) begin
          data_d  = DATA_SEND_I;
          state_d = (COMMAND_I || (DATA_SEND_I == ESC)) ? st_escape : st_data;
        end
      end
      st_escape: begin
        if (TX_READY_I) begin
          write    = 1'b1;
          data_out = ESC;
          state_d  = st_esc_gap;
        end
      end
      // One idle cycle gives UART-TX time to drop its ready before the payload.
      st_esc_gap: state_d = st_data;
      st_data: begin
        if (TX_READY_I) begin
          write    = 1'b1;
          data_out = data_q;
          state_d  = st_gap;
        end
      end
      st_gap:     state_d = st_idle;
      default:    state_d = st_idle;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= st_idle;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Reset is idle, so ready must be masked while reset is held.
  assign TX_READY_O  = tx_ready & RST_NI;
  assign WRITE_O     = write;
  assign DATA_SEND_O = data_out;

endmodule

// File: doc/tx_escape.md
Name: tx_escape

Overview:
- Transmit-side counterpart of the UART escape receiver.
- Sits between the TAP and UART-TX. Accepts one byte at a time from the TAP, each tagged as data or command, and emits the escaped byte stream to UART-TX.
- Command bytes are prefixed with ESC. Data bytes equal to ESC are sent as ESC,ESC; the TAP treats command value ESC as a literal ESC data byte.
- All other data bytes pass through unchanged.

Parameters:
- ESC, 8'hB1, escape symbol inserted into the TX stream.

Ports:
- CLK_I  in  1  clock; all logic is rising-edge.
- RST_NI  in  1  asynchronous, active-low reset.
- DATA_SEND_I  in  8  byte from TAP.
- COMMAND_I  in  1  1 = DATA_SEND_I is a command byte, 0 = data byte.
- WRITE_I  in  1  TAP write strobe; sampled only while TX_READY_O=1.
- TX_READY_O  out  1  block can accept a new byte from the TAP.
- TX_READY_I  in  1  UART-TX can accept a byte this cycle.
- WRITE_O  out  1  one-cycle write strobe to UART-TX.
- DATA_SEND_O  out  8  byte to UART-TX; valid while WRITE_O=1.

Behaviour:
- Reset (RST_NI=0, asynchronous):
  - state=st_idle, data register=0.
  - WRITE_O=0, DATA_SEND_O=0, TX_READY_O=0 while reset is held.
  - First cycle after release: TX_READY_O=1.
  - Reset mid-operation aborts the pending byte; nothing further is emitted for it.
- Register: 8-bit data register. Outputs are combinational from state, TX_READY_I and the data register.
- States:
  - st_idle:
    - TX_READY_O=1.
    - If WRITE_I=1: latch DATA_SEND_I.
    - If COMMAND_I=1 or DATA_SEND_I==ESC, go to st_escape; else go to st_data.
    - If WRITE_I=0: stay.
  - st_escape:
    - TX_READY_O=0.
    - If TX_READY_I=1: WRITE_O=1, DATA_SEND_O=ESC, go to st_esc_gap.
    - Else: WRITE_O=0, stay.
  - st_esc_gap: TX_READY_O=0, WRITE_O=0. Unconditionally go to st_data after one cycle; this lets UART-TX deassert TX_READY_I.
  - st_data:
    - TX_READY_O=0.
    - If TX_READY_I=1: WRITE_O=1, DATA_SEND_O=data register, go to st_gap.
    - Else: stay.
  - st_gap: TX_READY_O=0, WRITE_O=0. Unconditionally go to st_idle after one cycle.
- Latency, with TX_READY_I held high and WRITE_I accepted in cycle 0:
  - Plain data byte: WRITE_O in cycle 1, TX_READY_O high again in cycle 3. Throughput is 1 byte per 3 cycles.
  - Escaped byte: ESC written in cycle 1, payload written in cycle 3, TX_READY_O high again in cycle 5.
- Handshake rules:
  - WRITE_O is never asserted while TX_READY_I=0.
  - WRITE_O is never high in two consecutive cycles.
  - DATA_SEND_O=0 whenever WRITE_O=0.
  - WRITE_I while TX_READY_O=0 is ignored; no buffering and no error flag.
- Boundary cases:
  - TX_READY_I may drop indefinitely between ESC and payload. The payload is held and the pair is never split by another TAP byte.
  - COMMAND_I=1 with DATA_SEND_I==ESC produces ESC,ESC, identical to data ESC by protocol decision.
  - DATA_SEND_I and COMMAND_I are don't-care when WRITE_I=0.

Test Plan:
- Reset then data 8'h41 with TX_READY_I=1 -> WRITE_O pulses once in cycle 1 with DATA_SEND_O=8'h41; TX_READY_O low cycles 1–2, high cycle 3.
- Command 8'h05 (COMMAND_I=1) -> two WRITE_O pulses: 8'hB1 in cycle 1, 8'h05 in cycle 3; no other writes.
- Data 8'hB1 (COMMAND_I=0) -> 8'hB1 then 8'hB1; TX_READY_O returns high in cycle 5.
- Command 8'h07, TX_READY_I forced low for 10 cycles after the ESC write -> payload 8'h07 held, WRITE_O=0 throughout; written on the first cycle TX_READY_I=1. A WRITE_I of 8'h99 during the stall is not emitted.
- Random stream of 200 bytes (random COMMAND_I and values, including 8'hB1), fed through the escape receiver in a loopback -> received sequence and command flags match the sent ones. Data ESC arrives as command value 8'hB1.
- RST_NI pulled low asynchronously in st_data -> WRITE_O=0 and TX_READY_O=0 immediately; after release TX_READY_O=1 next cycle and the aborted byte is never written.
